// File: rtl/leb128_fetch_pkg.sv
// Shared LEB128 decode types: error codes and per-width byte limits.
package leb128_fetch_pkg;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MEM      = 2'd1,
    ERR_TOO_LONG = 2'd2,
    ERR_BOUNDS   = 2'd3
  } err_t;

  localparam logic [3:0] LEB_MAX32 = 4'd5;
  localparam logic [3:0] LEB_MAX64 = 4'd10;

endpackage

// File: rtl/leb128_accum.sv
// Combinational LEB128 byte merge: ORs the 7 payload bits in at the current shift,
// sign-extends and narrows on the final byte, and flags last byte / byte-count limit.
module leb128_accum
  import leb128_fetch_pkg::*;
(
  input  logic [63:0] acc,
  input  logic [7:0]  data,
  input  logic [6:0]  shift,
  input  logic [3:0]  count,
  input  logic        signed_mode,
  input  logic        width64,
  output logic [63:0] acc_next,
  output logic        last,
  output logic        overflow
);

  logic [63:0] merged;
  logic [6:0]  top;

  always_comb begin
    top      = shift + 7'd7;
    last     = ~data[7];
    overflow = (count + 4'd1) == (width64 ? LEB_MAX64 : LEB_MAX32);
    // Payload bits shifted past bit 63 fall off naturally.
    merged   = acc | ({57'd0, data[6:0]} << shift);
    if (last && signed_mode && data[6] && (top < 7'd64))
      merged = merged | (~64'd0 << top);
    acc_next = merged;
    if (last && !width64)
      acc_next = signed_mode ? {{32{merged[31]}}, merged[31:0]} : {32'd0, merged[31:0]};
  end

endmodule

// File: rtl/leb128_fetch.sv
// Multi-cycle LEB128 immediate fetch: one ROM byte per ADDR/DATA pair, result
// registered with a one-cycle done pulse; start is only accepted in IDLE.
module leb128_fetch
  import leb128_fetch_pkg::*;
#(
  parameter int MEM_DEPTH = 3,
  parameter int MEM_EXTRA = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       signed_mode,
  input  logic                       width64,
  input  logic [MEM_DEPTH:0]         start_addr,
  output logic [MEM_DEPTH:0]         mem_addr,
  output logic [MEM_EXTRA-1:0]       mem_extra,
  input  logic [2**MEM_EXTRA*8-1:0]  mem_data,
  input  logic                       mem_error,
  output logic                       busy,
  output logic                       done,
  output logic [63:0]                value,
  output logic [MEM_DEPTH:0]         next_addr,
  output logic [3:0]                 length,
  output err_t                       err
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

  localparam logic [MEM_DEPTH:0] ADDR_ONE = 1;

  state_t             state;
  logic [MEM_DEPTH:0] cur;
  logic [63:0]        acc;
  logic [6:0]         shift;
  logic [3:0]         count;
  logic               sm;
  logic               w64;
  logic [63:0]        acc_next;
  logic               last;
  logic               overflow;
  logic               unused_data;

  // Only the low byte of the ROM burst carries the immediate.
  assign unused_data = ^mem_data;
  assign mem_extra   = '0;

  leb128_accum u_accum (
    .acc         (acc),
    .data        (mem_data[7:0]),
    .shift       (shift),
    .count       (count),
    .signed_mode (sm),
    .width64     (w64),
    .acc_next    (acc_next),
    .last        (last),
    .overflow    (overflow)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cur       <= '0;
      acc       <= '0;
      shift     <= '0;
      count     <= '0;
      sm        <= 1'b0;
      w64       <= 1'b0;
      mem_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      value     <= '0;
      next_addr <= '0;
      length    <= '0;
      err       <= ERR_NONE;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            cur      <= start_addr;
            mem_addr <= start_addr;
            sm       <= signed_mode;
            w64      <= width64;
            acc      <= '0;
            shift    <= '0;
            count    <= '0;
            busy     <= 1'b1;
            state    <= S_ADDR;
          end
        end
        S_ADDR: state <= S_DATA;
        S_DATA: begin
          if (mem_error || last || overflow || (&cur)) begin
            done      <= 1'b1;
            state     <= S_DONE;
            next_addr <= cur + ADDR_ONE;
            length    <= mem_error ? count : count + 4'd1;
            value     <= (!mem_error && last) ? acc_next : '0;
            if (mem_error)     err <= ERR_MEM;
            else if (last)     err <= ERR_NONE;
            else if (overflow) err <= ERR_TOO_LONG;
            else               err <= ERR_BOUNDS;
          end else begin
            cur      <= cur + ADDR_ONE;
            mem_addr <= cur + ADDR_ONE;
            acc      <= acc_next;
            shift    <= shift + 7'd7;
            count    <= count + 4'd1;
            state    <= S_ADDR;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_leb128_fetch.sv
// Bench for leb128_fetch: directed vector table, hand sequences for reset/start/error
// corners, and random ROM images checked against an arithmetic LEB128 model.
module tb_leb128_fetch;
  import leb128_fetch_pkg::*;

  logic         clk = 1'b0;
  logic         reset, start, signed_mode, width64, mem_error;
  logic [3:0]   start_addr, mem_addr, mem_extra, next_addr, length;
  logic [127:0] mem_data;
  logic         busy, done;
  logic [63:0]  value;
  err_t         err;

  logic [7:0]   rom [16];
  logic         inj_en = 1'b0;
  logic [3:0]   inj_addr = 4'd0;
  int           checks = 0;
  int           fails = 0;

  leb128_fetch #(.MEM_DEPTH(3), .MEM_EXTRA(4)) dut (
    .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
    .width64(width64), .start_addr(start_addr), .mem_addr(mem_addr),
    .mem_extra(mem_extra), .mem_data(mem_data), .mem_error(mem_error),
    .busy(busy), .done(done), .value(value), .next_addr(next_addr),
    .length(length), .err(err)
  );

  always #5 clk = ~clk;

  // ROM with one-cycle read latency; junk in the upper burst bytes.
  always @(posedge clk) begin
    mem_data  <= {{120{1'b1}}, rom[mem_addr]};
    mem_error <= inj_en && (mem_addr == inj_addr);
  end

  typedef struct {
    logic [3:0]  addr;
    int          n;
    logic [79:0] bytes;
    logic        sm;
    logic        w;
    logic [63:0] v;
    logic [3:0]  len;
    logic [3:0]  nxt;
    logic [1:0]  e;
    int          cyc;
  } vec_t;

  vec_t tv [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_decode(input string name, input logic [3:0] a, input logic sm,
                            input logic w, input logic [63:0] ev, input logic [3:0] el,
                            input logic [3:0] en, input logic [1:0] ee, input int ecyc);
    int cyc;
    @(negedge clk);
    start_addr = a; signed_mode = sm; width64 = w; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, " done cycle"}, 64'(cyc), 64'(ecyc));
    chk({name, " value"}, value, ev);
    chk({name, " length"}, 64'(length), 64'(el));
    chk({name, " next_addr"}, 64'(next_addr), 64'(en));
    chk({name, " err"}, 64'(err), 64'(ee));
    @(negedge clk);
    chk({name, " done pulse ends"}, 64'({done, busy}), 64'd0);
  endtask

  // Reference: walk bytes from the ROM image using plain arithmetic.
  task automatic model(input logic [3:0] a0, input logic sm, input logic w,
                       output logic [63:0] v, output logic [3:0] len,
                       output logic [3:0] nxt, output logic [1:0] e, output int cyc);
    logic [63:0] acc;
    logic [7:0]  b;
    logic [3:0]  a;
    int sh, n, maxb;
    bit fin;
    acc = 0; sh = 0; n = 0; a = a0; maxb = w ? 10 : 5; fin = 0;
    v = 0; len = 0; nxt = 0; e = 0; cyc = 0;
    while (!fin) begin
      b   = rom[a];
      cyc = 2 * (n + 1) + 1;
      nxt = a + 4'd1;
      if (inj_en && a == inj_addr) begin
        e = 2'd1; len = 4'(n); v = 0; fin = 1;
      end else begin
        n++;
        len = 4'(n);
        acc = acc | (64'(b[6:0]) << sh);
        if (!b[7]) begin
          // Negative value: subtracting 2^(sh+7) fills the upper bits with ones.
          if (sm && b[6] && sh + 7 < 64) acc = acc - (64'd1 << (sh + 7));
          if (!w) acc = sm ? {{32{acc[31]}}, acc[31:0]} : {32'd0, acc[31:0]};
          v = acc; e = 2'd0; fin = 1;
        end else if (n == maxb) begin
          e = 2'd2; fin = 1;
        end else if (a == 4'hF) begin
          e = 2'd3; fin = 1;
        end else begin
          a  = a + 4'd1;
          sh = sh + 7;
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [8:0]  mask;
    logic [63:0] mv;
    logic [3:0]  ml, mn;
    logic [1:0]  me;
    int          mc;
    logic [7:0]  b;

    tv[0]  = '{4'd0,  1,  80'h2A,                   1'b0, 1'b0, 64'd42,                  4'd1,  4'd1,  2'd0, 3};
    tv[1]  = '{4'd0,  3,  80'h268EE5,               1'b0, 1'b0, 64'd624485,              4'd3,  4'd3,  2'd0, 7};
    tv[2]  = '{4'd0,  1,  80'h7F,                   1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'd1,  4'd1,  2'd0, 3};
    tv[3]  = '{4'd0,  3,  80'h78BBC0,               1'b1, 1'b0, 64'hFFFF_FFFF_FFFE_1DC0, 4'd3,  4'd3,  2'd0, 7};
    tv[4]  = '{4'd0,  6,  80'h808080808080,         1'b0, 1'b0, 64'd0,                   4'd5,  4'd5,  2'd2, 11};
    tv[5]  = '{4'd15, 1,  80'h80,                   1'b0, 1'b0, 64'd0,                   4'd1,  4'd0,  2'd3, 3};
    tv[6]  = '{4'd2,  10, 80'h7F808080808080808080, 1'b1, 1'b1, 64'h8000_0000_0000_0000, 4'd10, 4'd12, 2'd0, 21};
    tv[7]  = '{4'd4,  5,  80'h7FFFFFFFFF,           1'b0, 1'b0, 64'h0000_0000_FFFF_FFFF, 4'd5,  4'd9,  2'd0, 11};
    tv[8]  = '{4'd4,  5,  80'h7FFFFFFFFF,           1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'd5,  4'd9,  2'd0, 11};
    tv[9]  = '{4'd10, 3,  80'h03FFFF,               1'b0, 1'b1, 64'h0000_0000_0000_FFFF, 4'd3,  4'd13, 2'd0, 7};
    tv[10] = '{4'd7,  1,  80'h3F,                   1'b1, 1'b1, 64'd63,                  4'd1,  4'd8,  2'd0, 3};

    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    reset = 1'b1; start = 1'b0; signed_mode = 1'b0; width64 = 1'b0; start_addr = 4'd0;
    repeat (3) @(negedge clk);
    chk("reset busy/done", 64'({busy, done}), 64'd0);
    chk("reset value", value, 64'd0);
    chk("reset addrs", 64'({mem_addr, mem_extra, next_addr, length}), 64'd0);
    chk("reset err", 64'(err), 64'(ERR_NONE));
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      for (int k = 0; k < tv[i].n; k++) rom[4'(tv[i].addr + 4'(k))] = tv[i].bytes[8*k +: 8];
      run_decode($sformatf("vec%0d", i), tv[i].addr, tv[i].sm, tv[i].w,
                 tv[i].v, tv[i].len, tv[i].nxt, tv[i].e, tv[i].cyc);
    end

    // ROM error on the first and on the second byte.
    rom[0] = 8'h80; inj_en = 1'b1; inj_addr = 4'd0;
    run_decode("memerr first", 4'd0, 1'b0, 1'b0, 64'd0, 4'd0, 4'd1, 2'd1, 3);
    rom[0] = 8'hE5; rom[1] = 8'h8E; rom[2] = 8'h26; inj_addr = 4'd1;
    run_decode("memerr second", 4'd0, 1'b0, 1'b0, 64'd0, 4'd1, 4'd2, 2'd1, 5);
    inj_en = 1'b0;

    // Start held high: ignored while busy and during done, taken the cycle after.
    rom[0] = 8'h05;
    @(negedge clk);
    start_addr = 4'd0; signed_mode = 1'b0; width64 = 1'b0; start = 1'b1; mask = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      mask[c] = done;
    end
    start = 1'b0;
    chk("held start done pattern", 64'(mask), 64'(9'b0_1000_1000));
    chk("held start value", value, 64'd5);

    // Reset during the second ADDR of a 3-byte decode.
    rom[0] = 8'hE5; rom[1] = 8'h8E; rom[2] = 8'h26;
    run_decode("pre-reset", 4'd0, 1'b0, 1'b0, 64'd624485, 4'd3, 4'd3, 2'd0, 7);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("second ADDR mem_addr", 64'(mem_addr), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid reset busy/done", 64'({busy, done}), 64'd0);
    chk("mid reset value", value, 64'd0);
    chk("mid reset mem_addr", 64'(mem_addr), 64'd0);
    run_decode("post-reset", 4'd0, 1'b0, 1'b0, 64'd624485, 4'd3, 4'd3, 2'd0, 7);

    for (int r = 0; r < 60; r++) begin
      for (int i = 0; i < 16; i++) begin
        b = 8'($urandom_range(0, 255));
        mc = $urandom_range(0, 9);
        if (mc < 3) b[7] = 1'b0;
        else if (mc < 7) b[7] = 1'b1;
        rom[i] = b;
      end
      inj_en   = ($urandom_range(0, 7) == 0);
      inj_addr = 4'($urandom_range(0, 15));
      start_addr = 4'($urandom_range(0, 15));
      signed_mode = 1'($urandom_range(0, 1));
      width64 = 1'($urandom_range(0, 1));
      model(start_addr, signed_mode, width64, mv, ml, mn, me, mc);
      run_decode($sformatf("rand%0d", r), start_addr, signed_mode, width64, mv, ml, mn, me, mc);
    end
    inj_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/leb128_fetch.md
# leb128_fetch

Multi-cycle immediate fetch unit for the WASM core. Given a start address in program memory, it reads one byte per access from the ROM port, decodes a signed or unsigned LEB128 immediate of 32 or 64 bits, and returns the value, the address after the last byte, and an error code. It sits between the instruction decoder and the ROM (`genrom`), and its `value` output feeds the core's operand stack path.

## Interface

Parameters:
- `MEM_DEPTH`, default 3: address MSB index; addresses are `MEM_DEPTH+1` bits wide.
- `MEM_EXTRA`, default 4: ROM burst-select width; `mem_data` is `2**MEM_EXTRA*8` bits wide.

Ports:
- `clk`: in, 1. Single clock, rising edge.
- `reset`: in, 1. Synchronous, active-high.
- `start`: in, 1. Request decode; sampled only in IDLE.
- `signed_mode`: in, 1. 1 = SLEB128, 0 = ULEB128; latched on start.
- `width64`: in, 1. 1 = 64-bit immediate (max 10 bytes), 0 = 32-bit (max 5 bytes); latched on start.
- `start_addr`: in, `MEM_DEPTH+1`. Address of the first byte.
- `mem_addr`: out, `MEM_DEPTH+1`. ROM address.
- `mem_extra`: out, `MEM_EXTRA`. Always 0 (single-byte access).
- `mem_data`: in, `2**MEM_EXTRA*8`. ROM data; only `[7:0]` is used.
- `mem_error`: in, 1. ROM bounds or access error.
- `busy`: out, 1. High in every state except IDLE.
- `done`: out, 1. One-cycle completion pulse.
- `value`: out, 64. Decoded immediate; held until the next start.
- `next_addr`: out, `MEM_DEPTH+1`. Address after the last consumed byte.
- `length`: out, 4. Number of bytes consumed (1..10).
- `err`: out, 2. `ERR_NONE`, `ERR_MEM`, `ERR_TOO_LONG` or `ERR_BOUNDS`.

## Operation

- FSM states are IDLE, ADDR, DATA and DONE.
- **IDLE:** on `start`, latch `start_addr` into `cur`, latch the mode bits, and clear the accumulator, shift and count. Go to ADDR.
- **ADDR:** drive `mem_addr=cur`. Go to DATA.
- **DATA:** sample `mem_data[7:0]` and `mem_error`. Then, in priority order:
  - `mem_error`: set `err=ERR_MEM` and go to DONE.
  - OR `byte[6:0] << shift` into the accumulator, discarding bits at or above 64. Increment count.
  - bit7=0 (last byte): apply sign extension, then go to DONE.
  - count equals the maximum (5 or 10): set `ERR_TOO_LONG` and go to DONE.
  - `cur` is all-ones: set `ERR_BOUNDS`, because the address would wrap. Go to DONE.
  - Otherwise increment `cur`, add 7 to `shift`, and go to ADDR.
- **Sign extension:** applies only when `signed_mode`, the last byte's bit6 is 1, and `shift+7 < 64`. All bits at or above `shift+7` are set to 1.
- **32-bit mode:** the final value is `acc[31:0]`, sign-extended to 64 bits when signed and zero-extended when unsigned. Unused high bits of the final byte are not checked.
- **DONE:** `done=1` for one cycle. Update `value`, `next_addr=cur+1` and `length`. On error, `value=0`. Return to IDLE.
- `start` is ignored while `busy`. `start` in the same cycle as `done` is also ignored; it is accepted the following cycle if still high.
- **Reset** from any state: return to IDLE. Reset values are `mem_addr=0`, `mem_extra=0`, `busy=0`, `done=0`, `value=0`, `next_addr=0`, `length=0`, `err=ERR_NONE`. An in-flight decode is discarded.

## Timing

- ROM read latency is one cycle: an address driven in cycle N gives data valid in cycle N+1.
- Each byte takes 2 cycles (ADDR then DATA). Accesses are not pipelined.
- Take `start` sampled at edge 0. For an n-byte immediate, `done` is high during cycle 2n+1, i.e. after edge 2n.
- Minimum latency is 3 cycles (1-byte immediate). Maximum is 21 cycles (10 bytes).
- `value`, `next_addr`, `length` and `err` become valid in the same cycle as `done`. They stay stable until the next accepted `start`.
- `mem_addr` holds `cur` in both ADDR and DATA, so the ROM address is stable across the read.

## Structure

- **Shared package** (alongside the core's defines): the `err` enum, plus constants `LEB_MAX32=5` and `LEB_MAX64=10`.
- **FSM state enum:** local to the module.
- **Sub-module `leb128_accum`:** purely combinational. Takes byte, shift, signed flag and width; produces the next accumulator and the last/overflow flags. It is reused later by the core's memarg decode.

## Test plan

- ROM byte `0x2A` at address 0, unsigned, 32-bit, `start_addr=0`: `value=42`, `length=1`, `next_addr=1`, `err=NONE`, `done` in cycle 3.
- Bytes `E5 8E 26`, unsigned, 32-bit: `value=624485`, `length=3`, `done` in cycle 7.
- Byte `7F`, signed, 64-bit: `value=64'hFFFF_FFFF_FFFF_FFFF`. Bytes `C0 BB 78`, signed, 32-bit: `value=-123456` sign-extended to 64 bits.
- Six bytes of `0x80`, 32-bit: `err=ERR_TOO_LONG`, `length=5`, `value=0`, `done` in cycle 11.
- `start_addr=15` with byte `0x80` (`MEM_DEPTH=3`): `err=ERR_BOUNDS` after 1 byte. Separately, forcing `mem_error` during the first DATA cycle gives `err=ERR_MEM`.
- Reset asserted during the second ADDR of a 3-byte decode: the next cycle shows `busy=0`, `done=0`, `value=0`, `mem_addr=0`. A fresh `start` then decodes correctly.
